// File: rtl/fetch_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_pkg : shared types and defaults for the instruction fetch slice
// Rev 1.0
// ------------------------------------------------------------------
package fetch_pkg;

  localparam int          c_ADDR_W   = 64;
  localparam int          c_INST_W   = 64;
  localparam logic [63:0] c_RESET_PC = 64'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_skid_buf : one-entry {inst, pc} holding buffer for backpressure
// Rev 1.0
// ------------------------------------------------------------------
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int INST_W = c_INST_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              capture,
  input  logic              pop,
  input  logic              flush,
  input  logic [INST_W-1:0] cap_inst,
  input  logic [ADDR_W-1:0] cap_pc,
  output logic              full,
  output logic [INST_W-1:0] held_inst,
  output logic [ADDR_W-1:0] held_pc
);

  logic              r_full;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc;

  // flush wins over capture so a redirect never leaves a stale entry behind
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_full <= 1'b0;
    end else if (capture) begin
      r_full <= 1'b1;
    end else if (pop) begin
      r_full <= 1'b0;
    end
    if (capture && !flush) begin
      r_inst <= cap_inst;
      r_pc   <= cap_pc;
    end
  end

  assign full      = r_full;
  assign held_inst = r_inst;
  assign held_pc   = r_pc;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// inst_fetch_ctrl : PC sequencing, fetch issue and valid/ready delivery
// Rev 1.0
// ------------------------------------------------------------------
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               ADDR_W    = c_ADDR_W,
  parameter int               INST_W    = c_INST_W,
  parameter int               MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted,
  output logic              fetch_fault
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_req_valid;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_fault;

  logic              w_resp_valid;
  logic              w_in_range;
  logic              w_issue_ok;
  logic              w_issue;
  logic              w_fault;
  logic              w_capture;
  logic              w_pop;
  logic              w_skid_full;
  logic [INST_W-1:0] w_skid_inst;
  logic [ADDR_W-1:0] w_skid_pc;

  assign mem_addr     = redirect_valid ? redirect_pc : r_pc;
  assign w_resp_valid = r_req_valid;
  assign w_in_range   = (mem_addr < ADDR_W'(MEM_DEPTH));

  // a fetch slot is available; range decides between issuing and faulting
  assign w_issue_ok = (r_state == ST_RUN) && !halt_req && !w_skid_full &&
                      (!w_resp_valid || inst_ready || redirect_valid);
  assign w_issue    = w_issue_ok && w_in_range;
  assign w_fault    = w_issue_ok && !w_in_range;

  assign w_capture  = w_resp_valid && !inst_ready && !redirect_valid;
  assign w_pop      = w_skid_full && inst_ready;

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .capture   (w_capture),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .cap_inst  (mem_inst),
    .cap_pc    (r_req_pc),
    .full      (w_skid_full),
    .held_inst (w_skid_inst),
    .held_pc   (w_skid_pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start && !halt_req) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (halt_req)     w_state_nxt = ST_DRAIN;
        else if (w_fault) w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: if (!r_req_valid && !w_skid_full) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    halted = (r_state == ST_IDLE);
  end

  // a faulting fetch leaves pc pointing at the offending address
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_req_valid <= w_issue;
      if (w_issue) begin
        r_req_pc <= mem_addr;
        r_pc     <= mem_addr + ADDR_W'(1);
      end else if (redirect_valid) begin
        r_pc <= redirect_pc;
      end
      if (w_fault) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign inst_valid  = !redirect_valid && (w_skid_full || w_resp_valid);
  assign inst_out    = w_skid_full ? w_skid_inst : mem_inst;
  assign inst_pc     = w_skid_full ? w_skid_pc   : r_req_pc;
  assign fetch_fault = r_fault;

endmodule
`default_nettype wire
